// File: rtl/npu_pkg.sv
// Shared NPU definitions: default cell sizing, 3x3 cell index map
// and the window generator FSM state encoding.
package npu_pkg;

  localparam int CELL_BIT = 8;
  localparam int N_CELL   = 9;
  localparam int WIN_DIM  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } win_state_e;

  // r=0 is the oldest row, c=0 the leftmost column
  function automatic int cell_idx(input int r, input int c);
    return WIN_DIM * r + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: shifts one entry per enabled cycle,
// output is the sample written DEPTH enables earlier.
module line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_mem[0] <= i_din;
      for (int i = 1; i < DEPTH; i++)
        r_mem[i] <= r_mem[i-1];
    end
  end

  assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator feeding the arithmetic core.
// Optional stride-2 mode enabled by defining CONV_WINDOW_STRIDE2_EN.
module conv_window_gen
  import npu_pkg::*;
#(
  parameter int cell_bit = CELL_BIT,
  parameter int N_cell   = N_CELL,
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [cell_bit-1:0]        pix_in,
  input  logic                       pix_valid,
  input  logic                       sof,
`ifdef CONV_WINDOW_STRIDE2_EN
  input  logic                       stride2,
`endif
  output logic [cell_bit*N_cell-1:0] win_out,
  output logic                       win_en,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  win_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_col, w_col_cur, w_col_nxt;
  logic [RW-1:0] r_row, w_row_cur, w_row_nxt;
  logic          w_acc, w_last, w_emit, w_stride_ok;

  logic [cell_bit-1:0] w_lb1, w_lb2;
  logic [cell_bit-1:0] r_win [WIN_DIM][WIN_DIM];
  logic [cell_bit-1:0] w_win [WIN_DIM][WIN_DIM];
  logic [cell_bit*N_cell-1:0] w_pack;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(cell_bit)) u_lb1 (
    .i_clk  (clk),
    .i_en   (w_acc),
    .i_din  (pix_in),
    .o_dout (w_lb1)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(cell_bit)) u_lb2 (
    .i_clk  (clk),
    .i_en   (w_acc),
    .i_din  (w_lb1),
    .o_dout (w_lb2)
  );

`ifdef CONV_WINDOW_STRIDE2_EN
  logic r_s2;
  always_ff @(posedge clk) begin
    if (!reset) r_s2 <= 1'b0;
    else if (sof) r_s2 <= stride2;
  end
  assign w_stride_ok = !r_s2 || (!w_row_cur[0] && !w_col_cur[0]);
`else
  assign w_stride_ok = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_col_cur   = sof ? '0 : r_col;
    w_row_cur   = sof ? '0 : r_row;
    w_col_nxt   = w_col_cur;
    w_row_nxt   = w_row_cur;
    // pixels arriving after the frame end are dropped until sof
    w_acc  = pix_valid && (r_state != ST_DONE || sof);
    w_last = w_acc && w_row_cur == ROW_LAST
                   && w_col_cur == COL_LAST;
    w_emit = w_acc && w_stride_ok
                   && w_row_cur >= RW'(2)
                   && w_col_cur >= CW'(2);
    if (w_acc) begin
      if (w_col_cur == COL_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = w_last ? '0 : w_row_cur + RW'(1);
      end else begin
        w_col_nxt = w_col_cur + CW'(1);
      end
    end
    if (w_last)     w_state_nxt = ST_DONE;
    else if (w_acc) w_state_nxt = ST_ACTIVE;
    else if (sof)   w_state_nxt = ST_IDLE;
  end

  always_comb begin
    for (int r = 0; r < WIN_DIM; r++)
      for (int c = 0; c < WIN_DIM - 1; c++)
        w_win[r][c] = r_win[r][c+1];
    w_win[0][2] = w_lb2;
    w_win[1][2] = w_lb1;
    w_win[2][2] = pix_in;
  end

  always_comb begin
    w_pack = '0;
    for (int r = 0; r < WIN_DIM; r++)
      for (int c = 0; c < WIN_DIM; c++)
        w_pack[cell_bit*cell_idx(r, c) +: cell_bit] = w_win[r][c];
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_win <= w_win;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      win_out    <= '0;
      win_en     <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      win_en     <= w_emit;
      frame_done <= w_last;
      busy       <= (w_state_nxt == ST_ACTIVE);
      if (w_emit) win_out <= w_pack;
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed table-driven bench for conv_window_gen (4x4 frames,
// plus a 6x6 stride-2 frame when CONV_WINDOW_STRIDE2_EN is defined).
module tb_conv_window_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        pix_valid = 1'b0;
  logic        sof = 1'b0;
  logic [71:0] win_out;
  logic        win_en, frame_done, busy;

  always #5 clk = ~clk;

  conv_window_gen #(
    .cell_bit(8), .N_cell(9), .IMG_W(4), .IMG_H(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .sof        (sof),
`ifdef CONV_WINDOW_STRIDE2_EN
    .stride2    (1'b0),
`endif
    .win_out    (win_out),
    .win_en     (win_en),
    .frame_done (frame_done),
    .busy       (busy)
  );

`ifdef CONV_WINDOW_STRIDE2_EN
  logic [7:0]  s6_pix = '0;
  logic        s6_valid = 1'b0;
  logic        s6_sof = 1'b0;
  logic [71:0] s6_out;
  logic        s6_en, s6_fd, s6_busy;

  conv_window_gen #(
    .cell_bit(8), .N_cell(9), .IMG_W(6), .IMG_H(6)
  ) dut6 (
    .clk        (clk),
    .reset      (reset),
    .pix_in     (s6_pix),
    .pix_valid  (s6_valid),
    .sof        (s6_sof),
    .stride2    (1'b1),
    .win_out    (s6_out),
    .win_en     (s6_en),
    .frame_done (s6_fd),
    .busy       (s6_busy)
  );
`endif

  typedef struct {
    int cells[9];
    bit fd;
  } vec_t;

  vec_t        tbl[4];
  int          total = 0;
  int          bad = 0;
  logic [71:0] got_q[$];
  bit          fd_q[$];
  int          fd_cnt = 0;
  int          consec = 0;
  bit          prev_en = 0;
  int          en_cnt = 0;

  task automatic chk(input string name, input logic [71:0] act,
                     input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit v, input int p, input bit s);
    pix_valid = v;
    pix_in    = 8'(p);
    sof       = s;
    @(posedge clk);
    #1;
    if (win_en) begin
      got_q.push_back(win_out);
      fd_q.push_back(frame_done);
      en_cnt++;
    end
    if (frame_done) fd_cnt++;
    if (win_en && prev_en) consec++;
    prev_en = win_en;
  endtask

  function automatic logic [71:0] exp_win(input int i, input int off);
    logic [71:0] e;
    for (int k = 0; k < 9; k++)
      e[8*k +: 8] = 8'(tbl[i].cells[k] + off);
    return e;
  endfunction

  task automatic clear_q();
    got_q.delete();
    fd_q.delete();
    fd_cnt = 0;
    consec = 0;
    en_cnt = 0;
  endtask

  task automatic check_frame(input string name, input int off);
    chk({name, "_count"}, 72'(got_q.size()), 72'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      chk($sformatf("%s_win%0d", name, i), got_q[i], exp_win(i, off));
      chk($sformatf("%s_fd%0d", name, i), 72'(fd_q[i]), 72'(tbl[i].fd));
    end
    chk({name, "_fdcnt"}, 72'(fd_cnt), 72'd1);
  endtask

  task automatic send_frame(input int off, input bit gap);
    for (int i = 0; i < 16; i++) begin
      step(1, off + i + 1, i == 0);
      if (gap) step(0, 0, 0);
    end
  endtask

  initial begin
    tbl[0].cells = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    tbl[0].fd    = 0;
    tbl[1].cells = '{2, 3, 4, 6, 7, 8, 10, 11, 12};
    tbl[1].fd    = 0;
    tbl[2].cells = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
    tbl[2].fd    = 0;
    tbl[3].cells = '{6, 7, 8, 10, 11, 12, 14, 15, 16};
    tbl[3].fd    = 1;

    reset = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("rst_win_out", win_out, 72'd0);
    chk("rst_win_en", 72'(win_en), 72'd0);
    chk("rst_frame_done", 72'(frame_done), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
    reset = 1'b1;
    step(0, 0, 0);

    // back-to-back frame
    clear_q();
    for (int i = 0; i < 16; i++) begin
      step(1, i + 1, i == 0);
      if (i == 0) chk("busy_first", 72'(busy), 72'd1);
    end
    chk("busy_done", 72'(busy), 72'd0);
    check_frame("b2b", 0);

    // gapped frame
    clear_q();
    send_frame(0, 1);
    check_frame("gap", 0);
    chk("gap_consec", 72'(consec), 72'd0);
    chk("gap_hold", win_out, exp_win(3, 0));
    chk("gap_en_low", 72'(win_en), 72'd0);

    // pixels after frame end without sof are ignored
    clear_q();
    for (int i = 0; i < 5; i++) step(1, 250 + i, 0);
    chk("post_no_win", 72'(en_cnt), 72'd0);
    chk("post_busy", 72'(busy), 72'd0);
    clear_q();
    send_frame(100, 0);
    check_frame("restart", 100);

    // reset low mid-frame on a window-completing pixel
    clear_q();
    for (int i = 0; i < 10; i++) step(1, 61 + i, i == 0);
    reset = 1'b0;
    step(1, 71, 0);
    chk("mrst_win_en", 72'(win_en), 72'd0);
    chk("mrst_win_out", win_out, 72'd0);
    chk("mrst_busy", 72'(busy), 72'd0);
    chk("mrst_fd", 72'(frame_done), 72'd0);
    reset = 1'b1;
    clear_q();
    send_frame(200, 0);
    check_frame("after_rst", 200);

    // sof mid-frame at pixel 7
    clear_q();
    for (int i = 0; i < 6; i++) step(1, 31 + i, i == 0);
    send_frame(150, 0);
    check_frame("mid_sof", 150);

`ifdef CONV_WINDOW_STRIDE2_EN
    begin
      logic [71:0] q6[$];
      int ends[4] = '{15, 17, 27, 29};
      for (int i = 0; i < 36; i++) begin
        s6_valid = 1'b1;
        s6_pix   = 8'(i + 1);
        s6_sof   = (i == 0);
        @(posedge clk);
        #1;
        if (s6_en) q6.push_back(s6_out);
      end
      s6_valid = 1'b0;
      chk("s2_count", 72'(q6.size()), 72'd4);
      for (int w = 0; w < 4 && w < q6.size(); w++) begin
        logic [71:0] e;
        int r0, c0;
        r0 = (ends[w] - 1) / 6 - 2;
        c0 = (ends[w] - 1) % 6 - 2;
        for (int k = 0; k < 9; k++)
          e[8*k +: 8] = 8'(6 * (r0 + k / 3) + c0 + k % 3 + 1);
        chk($sformatf("s2_win%0d", w), q6[w], e);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
